// File: rtl/stage_mem_hs_pkg.sv
// Shared types and helpers for the handshaked MEM stage.
// FSM state, WB control bubble and parameter sanity check.
`ifndef STAGE_MEM_HS_PKG_SV
`define STAGE_MEM_HS_PKG_SV

`define STAGE_MEM_HS_CHECK(aw, dw, to) \
  if (((aw) > (dw)) || ((to) < 1)) begin : g_param_err \
    $error("stage_mem_hs: need ADDR_W <= DATA_W and TIMEOUT >= 1"); \
  end

package stage_mem_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic res_src;
    logic reg_wr;
  } wb_ctrl_t;

  function automatic wb_ctrl_t bubble_ctrl();
    wb_ctrl_t c;
    c.res_src = 1'b0;
    c.reg_wr  = 1'b0;
    return c;
  endfunction

endpackage

`endif

// File: rtl/stage_mem_hs_fsm.sv
// Access FSM: tracks an outstanding request, counts wait cycles
// and flags a hung access once TIMEOUT wait cycles have elapsed.
module mem_access_fsm
  import stage_mem_hs_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic access_i,
  input  logic ready_i,
  output logic req_o,
  output logic timeout_hit_o,
  output logic stall_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A coinciding ready always wins over the timeout.
  assign timeout_hit_o = (state_q == WAIT)
                       & (cnt_q == CW'(TIMEOUT))
                       & ~ready_i;

  assign req_o   = access_i & ~timeout_hit_o & rst_n;
  assign stall_o = req_o & ~ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (access_i && !ready_i) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (ready_i || timeout_hit_o || !access_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/stage_mem_hs.sv
// MEM pipeline stage with req/ready data-memory port, bubble
// insertion into WB, timeout watchdog and stall-cycle counter.
module stage_mem_hs
  import stage_mem_hs_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              ResultSrc_MEM,
  input  logic              RegWrite_MEM,
  input  logic [REG_W-1:0]  rd_MEM,
  input  logic [DATA_W-1:0] alu_result_MEM,
  input  logic [DATA_W-1:0] write_data_MEM,
  input  logic              err_clr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_MEM,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic              ResultSrc_WB,
  output logic              RegWrite_WB,
  output logic [REG_W-1:0]  rd_WB,
  output logic              mem_error,
  output logic [CNT_W-1:0]  stall_cycles
);

  `STAGE_MEM_HS_CHECK(ADDR_W, DATA_W, TIMEOUT)

  logic access, timeout_hit;

  assign access = MemRead_MEM | MemWrite_MEM;

  mem_access_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (reset_n),
    .access_i     (access),
    .ready_i      (dmem_ready),
    .req_o        (dmem_req),
    .timeout_hit_o(timeout_hit),
    .stall_o      (stall_MEM)
  );

  assign dmem_we    = dmem_req & MemWrite_MEM;
  assign dmem_addr  = dmem_req ? alu_result_MEM[ADDR_W-1:0] : '0;
  assign dmem_wdata = dmem_req ? write_data_MEM : '0;

  wb_ctrl_t          ctrl_q, ctrl_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  sc_q, sc_d;

  always_comb begin
    ctrl_d = ctrl_q;
    rd_d   = rd_q;
    md_d   = md_q;
    alu_d  = alu_q;
    unique case (1'b1)
      !access: begin
        ctrl_d = '{res_src: ResultSrc_MEM, reg_wr: RegWrite_MEM};
        rd_d   = rd_MEM;
        md_d   = '0;
        alu_d  = alu_result_MEM;
      end
      access && dmem_ready: begin
        ctrl_d = '{res_src: ResultSrc_MEM, reg_wr: RegWrite_MEM};
        rd_d   = rd_MEM;
        md_d   = MemWrite_MEM ? '0 : dmem_rdata;
        alu_d  = alu_result_MEM;
      end
      access && !dmem_ready: begin
        // Stalled or timed out: WB sees a bubble, data fields hold.
        ctrl_d = bubble_ctrl();
        rd_d   = '0;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (timeout_hit)  err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    sc_d = sc_q;
    if (stall_MEM && !(&sc_q)) sc_d = sc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      md_q   <= '0;
      alu_q  <= '0;
      err_q  <= 1'b0;
      sc_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      md_q   <= md_d;
      alu_q  <= alu_d;
      err_q  <= err_d;
      sc_q   <= sc_d;
    end
  end

  assign ResultSrc_WB   = ctrl_q.res_src;
  assign RegWrite_WB    = ctrl_q.reg_wr;
  assign rd_WB          = rd_q;
  assign mem_data_out   = md_q;
  assign alu_result_out = alu_q;
  assign mem_error      = err_q;
  assign stall_cycles   = sc_q;

endmodule

// File: doc/stage_mem_hs.md
Name: stage_mem_hs

Overview:
Parametrised memory pipeline stage for the in-order core. It sits between the EX/MEM and MEM/WB boundaries and drives an external data-memory port through a req/ready handshake, so it tolerates variable-latency memory. While an access is outstanding it stalls upstream and inserts bubbles into WB. A watchdog aborts hung accesses, and a saturating counter records stall cycles.

Parameters:
DATA_W, 8, datapath width (ALU result, store data, load data)
ADDR_W, 8, data-memory address width; must be <= DATA_W
REG_W, 3, destination-register index width
TIMEOUT, 16, wait cycles before an outstanding access is aborted; must be >= 1
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
MemRead_MEM  in  1  load request
MemWrite_MEM  in  1  store request
ResultSrc_MEM  in  1  WB select: 1 = memory data, 0 = ALU result
RegWrite_MEM  in  1  register write enable
rd_MEM  in  REG_W  destination register
alu_result_MEM  in  DATA_W  ALU result; its low ADDR_W bits are the address
write_data_MEM  in  DATA_W  store data
err_clr  in  1  clears mem_error
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  address
dmem_wdata  out  DATA_W  write data
dmem_ready  in  1  access completes this cycle; dmem_rdata is valid for reads
dmem_rdata  in  DATA_W  read data
stall_MEM  out  1  upstream must hold the EX/MEM register
mem_data_out  out  DATA_W  registered load data to WB
alu_result_out  out  DATA_W  registered ALU result to WB
ResultSrc_WB  out  1  registered
RegWrite_WB  out  1  registered
rd_WB  out  REG_W  registered
mem_error  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- access = MemRead_MEM | MemWrite_MEM. If both are high, the access is a write (dmem_we = 1) and the read is ignored.
- dmem_req = access & (state == IDLE | state == WAIT). Handshake outputs are combinational from the EX/MEM inputs, which upstream holds stable while stall_MEM = 1.
- dmem_we = MemWrite_MEM, dmem_addr = alu_result_MEM[ADDR_W-1:0], dmem_wdata = write_data_MEM. All are 0 when dmem_req = 0.
- stall_MEM = dmem_req & ~dmem_ready & ~timeout_hit.
- FSM states: IDLE, WAIT.
- IDLE, no access: WB register loads the pass-through values. mem_data_out loads 0.
- IDLE, access with dmem_ready = 1 (zero-wait): WB register loads all fields. mem_data_out loads dmem_rdata for reads, 0 for writes. Stay in IDLE.
- IDLE, access with dmem_ready = 0: go to WAIT, wait counter = 1, WB register loads a bubble.
- Bubble: RegWrite_WB = 0, ResultSrc_WB = 0, rd_WB = 0; mem_data_out and alu_result_out hold.
- WAIT, dmem_ready = 1: complete as in the zero-wait case, go to IDLE. stall_MEM is low in that cycle.
- WAIT, dmem_ready = 0, wait counter < TIMEOUT: increment the counter, load a bubble.
- WAIT, wait counter == TIMEOUT, dmem_ready = 0 (timeout_hit):
  - dmem_req = 0 and stall_MEM = 0 this cycle.
  - WB loads a bubble, so the instruction is dropped.
  - mem_error is set; go to IDLE.
- If dmem_ready and timeout_hit coincide, dmem_ready wins and the access completes normally.
- Latency: WB outputs update on the clock edge that ends the completing cycle. Minimum is 1 cycle; otherwise 1 + wait cycles.
- mem_error: set on timeout, cleared by err_clr. If set and clear happen in the same cycle, set wins.
- stall_cycles increments on every cycle with stall_MEM = 1 and saturates at all-ones.
- reset_n low (any time, including mid-WAIT):
  - FSM goes to IDLE and the wait counter to 0.
  - All registered outputs go to 0, mem_error = 0, stall_cycles = 0.
  - dmem_req is forced to 0 while reset is asserted.
  - The in-flight access is abandoned, and the memory must tolerate a dropped req.

Decomposition:
- Shared package: the FSM state enum (IDLE, WAIT), a bubble-constant helper for the WB fields, and a parameter-check macro (ADDR_W <= DATA_W, TIMEOUT >= 1).
- One sub-module, mem_access_fsm: state, wait counter, timeout_hit, stall_MEM.
- Top level: handshake muxing, the WB register, mem_error and stall_cycles.

Test Plan:
- Zero-wait load: MemRead = 1, RegWrite = 1, ResultSrc = 1, alu = 0x10, rd = 5, dmem_ready = 1, rdata = 0x5A -> dmem_addr = 0x10; next edge mem_data_out = 0x5A, rd_WB = 5, RegWrite_WB = 1; stall_MEM never high.
- 3-wait store: MemWrite = 1, alu = 0x22, wdata = 0xC3, ready on the 4th cycle -> dmem_we = 1 and stall_MEM = 1 for 3 cycles. WB shows 3 bubbles, then RegWrite_WB = 0 for the store itself. stall_cycles = 3.
- ALU pass-through: no access, alu = 0x7E, rd = 2, RegWrite = 1 -> dmem_req = 0; next edge alu_result_out = 0x7E, RegWrite_WB = 1.
- Timeout with TIMEOUT = 4 and ready never asserted:
  - stall_MEM is high for 4 cycles, then dmem_req drops and mem_error = 1.
  - RegWrite_WB stays 0 throughout.
  - err_clr pulse -> mem_error = 0.
- Read and write both high: MemRead = MemWrite = 1 -> dmem_we = 1 and mem_data_out = 0 on completion.
- Reset mid-WAIT: pull reset_n low after 2 wait cycles -> dmem_req, stall_MEM and all WB outputs go to 0 immediately (asynchronously) and stall_cycles = 0. After release, a new zero-wait load completes normally.
